eth_tx_arbiter: RTL and testbench



---
 rtl/eth_tx_arbiter_if.sv | 43 ++++
 rtl/eth_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_if.sv
// Avalon-ST transmit bundle shared between the packet sources and the arbiter.
// master = sources and sink side, slave = arbiter.
interface eth_tx_arbiter_if #(
  parameter int CHANNEL_QTY = 3,
  parameter int ARBIT_LEVEL = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int INDX_WIDTH  = 10
) ();
  logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] arbit_request;
  logic [CHANNEL_QTY-1:0]             arbit_grant;
  logic [CHANNEL_QTY-1:0]             arbit_eop;
  logic [CHANNEL_QTY-1:0]             din_sop;
  logic [CHANNEL_QTY-1:0]             din_eop;
  logic [CHANNEL_QTY-1:0]             din_valid;
  logic [CHANNEL_QTY*DATA_WIDTH-1:0]  din_data;
  logic [CHANNEL_QTY*3-1:0]           din_empty;
  logic                               dout_sop;
  logic                               dout_eop;
  logic                               dout_valid;
  logic [DATA_WIDTH-1:0]              dout_data;
  logic [2:0]                         dout_empty;
  logic                               dout_error;
  logic [INDX_WIDTH-1:0]              arbit_index;
  logic [15:0]                        timeout_cnt;

  modport master (
    output arbit_request, din_sop, din_eop, din_valid,
    output din_data, din_empty,
    input  arbit_grant, arbit_eop,
    input  dout_sop, dout_eop, dout_valid,
    input  dout_data, dout_empty, dout_error,
    input  arbit_index, timeout_cnt
  );

  modport slave (
    input  arbit_request, din_sop, din_eop, din_valid,
    input  din_data, din_empty,
    output arbit_grant, arbit_eop,
    output dout_sop, dout_eop, dout_valid,
    output dout_data, dout_empty, dout_error,
    output arbit_index, timeout_cnt
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Priority + round-robin arbiter sharing one Avalon-ST Ethernet TX path,
// with per-packet grant hold, no-data watchdog and inter-packet gap.
module eth_tx_arbiter #(
  parameter int CHANNEL_QTY = 3,
  parameter int ARBIT_LEVEL = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 4096,
  parameter int INDX_WIDTH  = 10
) (
  input  logic clk,
  input  logic rst_n,
  eth_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(CHANNEL_QTY);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = 4;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          last_q, last_d;
  logic [CW-1:0]          sel_q, sel_d;
  logic [CHANNEL_QTY-1:0] grant_q, grant_d;
  logic [CHANNEL_QTY-1:0] aeop_q, aeop_d;
  logic                   in_pkt_q, in_pkt_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   dsop_q, dsop_d;
  logic                   deop_q, deop_d;
  logic                   dval_q, dval_d;
  logic                   derr_q, derr_d;
  logic [DATA_WIDTH-1:0]  ddata_q, ddata_d;
  logic [2:0]             demp_q, demp_d;
  logic [INDX_WIDTH-1:0]  idx_q, idx_d;
  logic [15:0]            tcnt_q, tcnt_d;

  logic [ARBIT_LEVEL-1:0] max_code;
  logic                   found;
  logic [CW-1:0]          win;
  int                     k;

  logic                   g_val, g_sop, g_eop;
  logic [DATA_WIDTH-1:0]  g_data;
  logic [2:0]             g_emp;

  // Highest code wins; ties go to the first match after last winner.
  always_comb begin
    max_code = '0;
    found    = 1'b0;
    win      = '0;
    k        = 0;
    for (int c = 0; c < CHANNEL_QTY; c++) begin
      if (bus.arbit_request[c*ARBIT_LEVEL +: ARBIT_LEVEL] > max_code)
        max_code = bus.arbit_request[c*ARBIT_LEVEL +: ARBIT_LEVEL];
    end
    for (int i = 0; i < CHANNEL_QTY; i++) begin
      k = int'(last_q) + 1 + i;
      if (k >= CHANNEL_QTY) k = k - CHANNEL_QTY;
      if (!found && max_code != '0 &&
          bus.arbit_request[k*ARBIT_LEVEL +: ARBIT_LEVEL] == max_code) begin
        found = 1'b1;
        win   = CW'(k);
      end
    end
  end

  assign g_val  = bus.din_valid[sel_q];
  assign g_sop  = bus.din_sop[sel_q];
  assign g_eop  = bus.din_eop[sel_q];
  assign g_data = bus.din_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_emp  = bus.din_empty[int'(sel_q)*3 +: 3];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    aeop_d   = '0;
    in_pkt_d = in_pkt_q;
    wd_d     = wd_q;
    gap_d    = gap_q;
    dsop_d   = 1'b0;
    deop_d   = 1'b0;
    dval_d   = 1'b0;
    derr_d   = 1'b0;
    ddata_d  = '0;
    demp_d   = '0;
    idx_d    = idx_q;
    tcnt_d   = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          last_d       = win;
          sel_d        = win;
          in_pkt_d     = 1'b0;
          wd_d         = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        unique case (1'b1)
          g_val: begin
            dval_d  = 1'b1;
            dsop_d  = g_sop;
            deop_d  = g_eop;
            ddata_d = g_data;
            demp_d  = g_emp;
            wd_d    = '0;
            if (g_sop) in_pkt_d = 1'b1;
            if (g_eop) in_pkt_d = 1'b0;
          end
          (wd_q == WW'(TIMEOUT - 1)): begin
            dval_d   = in_pkt_q;
            deop_d   = in_pkt_q;
            derr_d   = in_pkt_q;
            in_pkt_d = 1'b0;
            if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          end
          default: wd_d = wd_q + 1'b1;
        endcase
        if ((g_val && g_eop) || (!g_val && wd_q == WW'(TIMEOUT - 1))) begin
          grant_d = '0;
          aeop_d  = grant_q;
          idx_d   = idx_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= CW'(CHANNEL_QTY - 1);
      sel_q    <= '0;
      grant_q  <= '0;
      aeop_q   <= '0;
      in_pkt_q <= 1'b0;
      wd_q     <= '0;
      gap_q    <= '0;
      dsop_q   <= 1'b0;
      deop_q   <= 1'b0;
      dval_q   <= 1'b0;
      derr_q   <= 1'b0;
      ddata_q  <= '0;
      demp_q   <= '0;
      idx_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      aeop_q   <= aeop_d;
      in_pkt_q <= in_pkt_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
      dsop_q   <= dsop_d;
      deop_q   <= deop_d;
      dval_q   <= dval_d;
      derr_q   <= derr_d;
      ddata_q  <= ddata_d;
      demp_q   <= demp_d;
      idx_q    <= idx_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign bus.arbit_grant = grant_q;
  assign bus.arbit_eop   = aeop_q;
  assign bus.dout_sop    = dsop_q;
  assign bus.dout_eop    = deop_q;
  assign bus.dout_valid  = dval_q;
  assign bus.dout_error  = derr_q;
  assign bus.dout_data   = ddata_q;
  assign bus.dout_empty  = demp_q;
  assign bus.arbit_index = idx_q;
  assign bus.timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed-vector bench for eth_tx_arbiter: table of per-cycle vectors
// plus hand sequences for watchdog, reset and index wrap.
module tb_eth_tx_arbiter;
  localparam int N  = 3;
  localparam int AL = 2;
  localparam int DW = 64;
  localparam int GP = 2;
  localparam int TO = 16;
  localparam int IW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_tx_arbiter_if #(
    .CHANNEL_QTY(N), .ARBIT_LEVEL(AL),
    .DATA_WIDTH(DW), .INDX_WIDTH(IW)
  ) bus ();

  eth_tx_arbiter #(
    .CHANNEL_QTY(N), .ARBIT_LEVEL(AL), .DATA_WIDTH(DW),
    .GAP_CYCLES(GP), .TIMEOUT(TO), .INDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [5:0]  req;
    logic [2:0]  val, sop, eop;
    logic [7:0]  tag;
    logic [2:0]  emp;
    logic [2:0]  g, ae;
    logic        ov, os, oe;
    logic [63:0] od;
    logic [2:0]  oemp;
    logic [9:0]  idx;
  } vec_t;

  vec_t vq[$];
  int errs = 0;
  int checks = 0;

  function automatic logic [63:0] dv(int c, logic [7:0] t);
    return {8'(c), 48'h0, t};
  endfunction

  function automatic void add(
    input logic [5:0] r, input logic [2:0] v, s, e,
    input logic [7:0] t, input logic [2:0] m,
    input logic [2:0] g, ae, input logic ov, os, oe,
    input logic [63:0] od, input logic [2:0] oemp,
    input logic [9:0] idx);
    vec_t x;
    x.req = r; x.val = v; x.sop = s; x.eop = e;
    x.tag = t; x.emp = m; x.g = g; x.ae = ae;
    x.ov = ov; x.os = os; x.oe = oe; x.od = od;
    x.oemp = oemp; x.idx = idx;
    vq.push_back(x);
  endfunction

  function automatic void idl(input logic [5:0] r,
    input logic [2:0] g, input logic [9:0] idx);
    add(r, 0, 0, 0, 0, 0, g, 0, 0, 0, 0, 0, 0, idx);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] r, input logic [2:0] v, s, e,
                       input logic [7:0] t, input logic [2:0] m);
    bus.arbit_request = r;
    bus.din_valid = v;
    bus.din_sop = s;
    bus.din_eop = e;
    for (int c = 0; c < N; c++) begin
      bus.din_data[c*DW +: DW] = dv(c, t);
      bus.din_empty[c*3 +: 3] = m;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string p, input logic [2:0] g, ae,
    input logic ov, os, oe, oerr, input logic [63:0] od,
    input logic [2:0] oemp, input logic [9:0] idx);
    chk({p, "_grant"}, bus.arbit_grant, g);
    chk({p, "_aeop"}, bus.arbit_eop, ae);
    chk({p, "_valid"}, bus.dout_valid, ov);
    chk({p, "_sop"}, bus.dout_sop, os);
    chk({p, "_eop"}, bus.dout_eop, oe);
    chk({p, "_err"}, bus.dout_error, oerr);
    chk({p, "_data"}, bus.dout_data, od);
    chk({p, "_empty"}, bus.dout_empty, oemp);
    chk({p, "_index"}, bus.arbit_index, idx);
  endtask

  task automatic one_pkt(input int c);
    logic [5:0] r;
    logic [2:0] b;
    r = '0;
    r[c*AL] = 1'b1;
    b = '0;
    b[c] = 1'b1;
    drive(r, 0, 0, 0, 0, 0);
    tick();
    drive(0, b, b, b, 8'h55, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    // single channel, 4-beat packet
    idl(6'b000100, 3'b010, 0);
    add(6'b000100, 3'b010, 3'b010, 0, 8'hA1, 0, 3'b010, 0, 1, 1, 0, dv(1, 8'hA1), 0, 0);
    add(6'b000100, 3'b010, 0, 0, 8'hA2, 0, 3'b010, 0, 1, 0, 0, dv(1, 8'hA2), 0, 0);
    add(6'b000100, 3'b010, 0, 0, 8'hA3, 0, 3'b010, 0, 1, 0, 0, dv(1, 8'hA3), 0, 0);
    add(0, 3'b010, 0, 3'b010, 8'hA4, 3, 0, 3'b010, 1, 0, 1, dv(1, 8'hA4), 3, 1);
    idl(0, 0, 1);
    idl(0, 0, 1);
    // priority then round-robin 1,2,1,2
    idl(6'b010111, 3'b001, 1);
    add(6'b010100, 3'b001, 3'b001, 3'b001, 8'hB0, 0, 0, 3'b001, 1, 1, 1, dv(0, 8'hB0), 0, 2);
    idl(6'b010100, 0, 2);
    idl(6'b010100, 0, 2);
    idl(6'b010100, 3'b010, 2);
    add(6'b010100, 3'b010, 3'b010, 3'b010, 8'hB1, 0, 0, 3'b010, 1, 1, 1, dv(1, 8'hB1), 0, 3);
    idl(6'b010100, 0, 3);
    idl(6'b010100, 0, 3);
    idl(6'b010100, 3'b100, 3);
    add(6'b010100, 3'b100, 3'b100, 3'b100, 8'hB2, 0, 0, 3'b100, 1, 1, 1, dv(2, 8'hB2), 0, 4);
    idl(6'b010100, 0, 4);
    idl(6'b010100, 0, 4);
    idl(6'b010100, 3'b010, 4);
    add(6'b010100, 3'b010, 3'b010, 3'b010, 8'hB3, 0, 0, 3'b010, 1, 1, 1, dv(1, 8'hB3), 0, 5);
    idl(6'b010100, 0, 5);
    idl(6'b010100, 0, 5);
    idl(6'b010100, 3'b100, 5);
    add(0, 3'b100, 3'b100, 3'b100, 8'hB4, 0, 0, 3'b100, 1, 1, 1, dv(2, 8'hB4), 0, 6);
    idl(0, 0, 6);
    idl(0, 0, 6);
    // ch2 granted, ch1 noise, ch2 drops request
    idl(6'b100000, 3'b100, 6);
    add(6'b000100, 3'b110, 3'b110, 0, 8'hC0, 0, 3'b100, 0, 1, 1, 0, dv(2, 8'hC0), 0, 6);
    add(6'b000100, 3'b110, 0, 0, 8'hC1, 0, 3'b100, 0, 1, 0, 0, dv(2, 8'hC1), 0, 6);
    add(6'b000100, 3'b010, 0, 0, 8'hC2, 0, 3'b100, 0, 0, 0, 0, 0, 0, 6);
    add(6'b000100, 3'b110, 0, 3'b110, 8'hC3, 5, 0, 3'b100, 1, 0, 1, dv(2, 8'hC3), 5, 7);
    idl(6'b000100, 0, 7);
    idl(6'b000100, 0, 7);
    idl(6'b000100, 3'b010, 7);
    add(0, 3'b010, 3'b010, 3'b010, 8'hC4, 0, 0, 3'b010, 1, 1, 1, dv(1, 8'hC4), 0, 8);
    idl(0, 0, 8);
    idl(0, 0, 8);

    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_tcnt", bus.timeout_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].req, vq[i].val, vq[i].sop, vq[i].eop, vq[i].tag, vq[i].emp);
      tick();
      chk_out($sformatf("v%0d", i), vq[i].g, vq[i].ae, vq[i].ov,
              vq[i].os, vq[i].oe, 1'b0, vq[i].od, vq[i].oemp, vq[i].idx);
    end

    // watchdog abort after sop
    drive(6'b000001, 0, 0, 0, 0, 0);
    tick();
    chk("toA_grant", bus.arbit_grant, 3'b001);
    drive(0, 3'b001, 3'b001, 0, 8'hD0, 0);
    tick();
    chk("toA_sop", {bus.dout_valid, bus.dout_sop}, 2'b11);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk($sformatf("toA_hold%0d", i),
          {bus.arbit_grant, bus.arbit_eop, bus.dout_valid}, 7'b001_000_0);
    end
    tick();
    chk_out("toA", 0, 3'b001, 1, 0, 1, 1, 0, 0, 9);
    chk("toA_tcnt", bus.timeout_cnt, 1);
    tick();
    tick();

    // watchdog abort with no sop
    drive(6'b000001, 0, 0, 0, 0, 0);
    tick();
    chk("toB_grant", bus.arbit_grant, 3'b001);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk($sformatf("toB_hold%0d", i),
          {bus.arbit_grant, bus.arbit_eop, bus.dout_valid}, 7'b001_000_0);
    end
    tick();
    chk_out("toB", 0, 3'b001, 0, 0, 0, 0, 0, 0, 10);
    chk("toB_tcnt", bus.timeout_cnt, 2);
    tick();
    tick();

    // reset during beat 3
    drive(6'b010000, 0, 0, 0, 0, 0);
    tick();
    chk("rs_grant", bus.arbit_grant, 3'b100);
    drive(0, 3'b100, 3'b100, 0, 8'hE0, 0);
    tick();
    drive(0, 3'b100, 0, 0, 8'hE1, 0);
    tick();
    chk("rs_beat2", bus.dout_data, dv(2, 8'hE1));
    drive(0, 3'b100, 0, 0, 8'hE2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rs", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rs_tcnt", bus.timeout_cnt, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(6'b010101, 0, 0, 0, 0, 0);
    tick();
    chk("rs_tie", bus.arbit_grant, 3'b001);
    drive(0, 3'b001, 3'b001, 3'b001, 8'hE3, 0);
    tick();
    chk_out("rs_pkt", 0, 3'b001, 1, 1, 1, 0, dv(0, 8'hE3), 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // index wrap
    for (int i = 0; i < 1022; i++) one_pkt(1);
    chk("wrap_max", bus.arbit_index, 10'd1023);
    one_pkt(1);
    chk("wrap_zero", bus.arbit_index, 10'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
